// File: rtl/trivium_pkg.sv
// Shared constants, tap positions, FSM encoding and load helpers for the Trivium stream core.
package trivium_pkg;

    localparam int unsigned STATE_W    = 288;
    localparam int unsigned INIT_STEPS = 1152;
    localparam int unsigned KEY_W      = 80;
    localparam int unsigned IV_W       = 80;
    localparam int unsigned CNT_W      = 11;

    // Linear taps, AND-pair taps and cross-register feedback tap for each of t1/t2/t3
    localparam int unsigned T1_A   = 65;
    localparam int unsigned T1_B   = 92;
    localparam int unsigned T1_AN0 = 90;
    localparam int unsigned T1_AN1 = 91;
    localparam int unsigned T1_FB  = 170;

    localparam int unsigned T2_A   = 161;
    localparam int unsigned T2_B   = 176;
    localparam int unsigned T2_AN0 = 174;
    localparam int unsigned T2_AN1 = 175;
    localparam int unsigned T2_FB  = 263;

    localparam int unsigned T3_A   = 242;
    localparam int unsigned T3_B   = 287;
    localparam int unsigned T3_AN0 = 285;
    localparam int unsigned T3_AN1 = 286;
    localparam int unsigned T3_FB  = 68;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StInit = 2'd1,
        StRun  = 2'd2
    } trivium_fsm_e;

    // Byte 0 arrives in the top byte; the state wants it in the bottom byte
    function automatic logic [79:0] byte_rev80(input logic [79:0] v);
        logic [79:0] r;
        for (int i = 0; i < 10; i++) begin
            r[8*i +: 8] = v[8*(9-i) +: 8];
        end
        return r;
    endfunction

    function automatic logic [STATE_W-1:0] load_state(input logic [KEY_W-1:0] key,
                                                      input logic [IV_W-1:0]  iv);
        logic [STATE_W-1:0] s;
        s          = '0;
        s[79:0]    = byte_rev80(key);
        s[172:93]  = byte_rev80(iv);
        s[287:285] = 3'b111;
        return s;
    endfunction

    function automatic bit w_is_legal(input int unsigned w);
        return (w == 1) || (w == 2) || (w == 4) || (w == 8) ||
               (w == 16) || (w == 32) || (w == 64);
    endfunction

endpackage

// File: rtl/trivium_round.sv
// Single combinational Trivium step: current state in, next state and one keystream bit out.
module trivium_round
    import trivium_pkg::*;
(
    input  logic [STATE_W-1:0] i_s,
    output logic [STATE_W-1:0] o_s,
    output logic               o_z
);

    logic w_t1_lin, w_t2_lin, w_t3_lin;
    logic w_t1, w_t2, w_t3;

    // Keystream bit from linear taps, then nonlinear feedback for each register
    always_comb begin
        w_t1_lin = i_s[T1_A] ^ i_s[T1_B];
        w_t2_lin = i_s[T2_A] ^ i_s[T2_B];
        w_t3_lin = i_s[T3_A] ^ i_s[T3_B];
        o_z      = w_t1_lin ^ w_t2_lin ^ w_t3_lin;
        w_t1     = w_t1_lin ^ (i_s[T1_AN0] & i_s[T1_AN1]) ^ i_s[T1_FB];
        w_t2     = w_t2_lin ^ (i_s[T2_AN0] & i_s[T2_AN1]) ^ i_s[T2_FB];
        w_t3     = w_t3_lin ^ (i_s[T3_AN0] & i_s[T3_AN1]) ^ i_s[T3_FB];
    end

    // Three registers shift upward; each takes the feedback from its neighbour at bit 0
    assign o_s = {i_s[286:177], w_t2, i_s[175:93], w_t1, i_s[91:0], w_t3};

endmodule

// File: rtl/trivium_stream.sv
// Trivium keystream generator producing W bits per cycle with load/init/run control.
// Build option: define TRIVIUM_XOR_EN to add the Din port and emit Din ^ keystream.
module trivium_stream
    import trivium_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [KEY_W-1:0] Kin,
    input  logic [IV_W-1:0]  IVin,
    input  logic             Krdy,
`ifdef TRIVIUM_XOR_EN
    input  logic [W-1:0]     Din,
`endif
    input  logic             Dack,
    output logic [W-1:0]     Dout,
    output logic             Dvld,
    output logic             BSY,
    output logic             Kvld
);

    if (!w_is_legal(W)) begin : g_bad_w
        $error("trivium_stream: W must be one of 1, 2, 4, 8, 16, 32, 64");
    end

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(INIT_STEPS / W - 1);

    trivium_fsm_e       r_fsm, w_fsm_d;
    logic [STATE_W-1:0] r_state, w_state_d, w_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_d;
    logic [W-1:0]       w_ks;
    logic [W-1:0]       w_din;
    logic               w_cnt_last;

    // W chained rounds; stage 0 produces the first bit, which lands in the MSB
    for (genvar gi = 0; gi < W; gi++) begin : g_round
        logic [STATE_W-1:0] w_s_in;
        logic [STATE_W-1:0] w_s_out;
        if (gi == 0) begin : g_first
            assign w_s_in = r_state;
        end else begin : g_chain
            assign w_s_in = g_round[gi-1].w_s_out;
        end
        trivium_round u_round (
            .i_s (w_s_in),
            .o_s (w_s_out),
            .o_z (w_ks[W-1-gi])
        );
    end
    assign w_next = g_round[W-1].w_s_out;

`ifdef TRIVIUM_XOR_EN
    assign w_din = Din;
`else
    assign w_din = '0;
`endif

    assign w_cnt_last = (r_cnt == CntLast);

    // Next-state: Krdy wins over everything; INIT always steps; RUN steps only on accept
    always_comb begin
        w_fsm_d   = r_fsm;
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        if (EN) begin
            if (Krdy) begin
                w_fsm_d   = StInit;
                w_state_d = load_state(Kin, IVin);
                w_cnt_d   = '0;
            end else begin
                case (r_fsm)
                    StInit: begin
                        w_state_d = w_next;
                        if (w_cnt_last) begin
                            w_fsm_d = StRun;
                            w_cnt_d = '0;
                        end else begin
                            w_cnt_d = r_cnt + 1'b1;
                        end
                    end
                    StRun: begin
                        if (Dack) begin
                            w_state_d = w_next;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State registers; reset wipes all key material
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fsm   <= StIdle;
            r_state <= '0;
            r_cnt   <= '0;
        end else begin
            r_fsm   <= w_fsm_d;
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Outputs decode from FSM; Dout is forced to zero outside RUN so no init state leaks
    always_comb begin
        Dvld = (r_fsm == StRun);
        BSY  = (r_fsm == StInit);
        Kvld = EN && BSY && w_cnt_last && !Krdy;
        Dout = Dvld ? (w_ks ^ w_din) : '0;
    end

endmodule

// File: tb/tb_trivium_stream.sv
// Directed bench for trivium_stream: three widths (1, 8, 64) driven from shared controls.
module tb_trivium_stream;

`ifdef TRIVIUM_XOR_EN
    localparam bit XorEn = 1'b1;
`else
    localparam bit XorEn = 1'b0;
`endif

    localparam logic [79:0] KEY_A = 80'h0123456789abcdef0011;
    localparam logic [79:0] KEY_B = 80'hf0e1d2c3b4a596870f1e;
    localparam logic [79:0] IV_B  = 80'h00112233445566778899;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic        Krdy;
    logic [79:0] Kin;
    logic [79:0] IVin;
    logic        dack1, dack8, dack64;
    logic [7:0]  din8;
    logic [0:0]  dout1;
    logic [7:0]  dout8;
    logic [63:0] dout64;
    logic        dvld1, dvld8, dvld64;
    logic        bsy1, bsy8, bsy64;
    logic        kvld1, kvld8, kvld64;

    int checks   = 0;
    int failures = 0;

    logic [0:511] gold_a;
    logic [0:511] gold_b;
    logic [0:255] s1;

    always #5 CLK = ~CLK;

    trivium_stream #(.W(1)) u_dut1 (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .Kin  (Kin),
        .IVin (IVin),
        .Krdy (Krdy),
`ifdef TRIVIUM_XOR_EN
        .Din  (1'b0),
`endif
        .Dack (dack1),
        .Dout (dout1),
        .Dvld (dvld1),
        .BSY  (bsy1),
        .Kvld (kvld1)
    );

    trivium_stream #(.W(8)) u_dut8 (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .Kin  (Kin),
        .IVin (IVin),
        .Krdy (Krdy),
`ifdef TRIVIUM_XOR_EN
        .Din  (din8),
`endif
        .Dack (dack8),
        .Dout (dout8),
        .Dvld (dvld8),
        .BSY  (bsy8),
        .Kvld (kvld8)
    );

    trivium_stream #(.W(64)) u_dut64 (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .Kin  (Kin),
        .IVin (IVin),
        .Krdy (Krdy),
`ifdef TRIVIUM_XOR_EN
        .Din  (64'h0),
`endif
        .Dack (dack64),
        .Dout (dout64),
        .Dvld (dvld64),
        .BSY  (bsy64),
        .Kvld (kvld64)
    );

    // Reference cipher in the three-register form: a = s[92:0], b = s[176:93], c = s[287:177]
    function automatic logic [0:511] gen_gold(input logic [79:0] k, input logic [79:0] iv);
        bit a [1:93];
        bit b [1:84];
        bit c [1:111];
        logic [79:0]  kr, ivr;
        logic [0:511] ks;
        bit t1, t2, t3, z;
        for (int j = 0; j < 10; j++) begin
            kr[8*j +: 8]  = k[8*(9-j) +: 8];
            ivr[8*j +: 8] = iv[8*(9-j) +: 8];
        end
        for (int i = 1; i <= 93; i++)  a[i] = (i <= 80) ? kr[i-1] : 1'b0;
        for (int i = 1; i <= 84; i++)  b[i] = (i <= 80) ? ivr[i-1] : 1'b0;
        for (int i = 1; i <= 111; i++) c[i] = (i >= 109);
        ks = '0;
        for (int n = 0; n < 1152 + 512; n++) begin
            t1 = a[66] ^ a[93];
            t2 = b[69] ^ b[84];
            t3 = c[66] ^ c[111];
            z  = t1 ^ t2 ^ t3;
            t1 = t1 ^ (a[91] & a[92]) ^ b[78];
            t2 = t2 ^ (b[82] & b[83]) ^ c[87];
            t3 = t3 ^ (c[109] & c[110]) ^ a[69];
            for (int i = 93; i > 1; i--)  a[i] = a[i-1];
            for (int i = 84; i > 1; i--)  b[i] = b[i-1];
            for (int i = 111; i > 1; i--) c[i] = c[i-1];
            a[1] = t3;
            b[1] = t1;
            c[1] = t2;
            if (n >= 1152) ks[n-1152] = z;
        end
        return ks;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int k1, k8, k64, n8, bsy_drop, en_bad;
        logic [7:0] w0;

        RST = 1'b1; EN = 1'b1; Krdy = 1'b0; Kin = '0; IVin = '0;
        dack1 = 1'b0; dack8 = 1'b0; dack64 = 1'b0; din8 = 8'h00;
        gold_a = gen_gold(80'h0, 80'h0);
        gold_b = gen_gold(KEY_B, IV_B);

        // Reset state
        #12;
        check("rst_dvld", 64'(dvld8), 64'd0);
        check("rst_bsy", 64'(bsy8), 64'd0);
        check("rst_kvld", 64'(kvld8), 64'd0);
        check("rst_dout8", 64'(dout8), 64'd0);
        check("rst_dout64", dout64, 64'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        cyc();

        // Zero key / zero IV: Kvld latency for each width
        Krdy = 1'b1;
        cyc();
        Krdy = 1'b0;
        #1;
        check("init_bsy", 64'(bsy8), 64'd1);
        check("init_dvld", 64'(dvld8), 64'd0);
        k1 = -1; k8 = -1; k64 = -1; n8 = 0;
        for (int c = 1; c <= 1200; c++) begin
            if (kvld1 && k1 < 0) k1 = c;
            if (kvld8 && k8 < 0) k8 = c;
            if (kvld64 && k64 < 0) k64 = c;
            if (kvld8) n8++;
            cyc();
            #1;
        end
        check("kvld_lat_w1", 64'(k1), 64'd1152);
        check("kvld_lat_w8", 64'(k8), 64'd144);
        check("kvld_lat_w64", 64'(k64), 64'd18);
        check("kvld_pulse_w8", 64'(n8), 64'd1);
        check("run_dvld_w1", 64'(dvld1), 64'd1);
        check("run_bsy_w8", 64'(bsy8), 64'd0);

        // W=8 backpressure, then Din XOR path
        w0 = gold_a[0 +: 8];
        check("w8_word0", 64'(dout8), 64'(w0));
        din8 = 8'hFF;
        #1;
        check("w8_xor_ff", 64'(dout8), 64'(w0 ^ (XorEn ? 8'hFF : 8'h00)));
        din8 = 8'h00;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("w8_stall_hold", 64'(dout8), 64'(w0));
        end
        dack8 = 1'b1;
        cyc();
        dack8 = 1'b0;
        #1;
        check("w8_word1", 64'(dout8), 64'(gold_a[8 +: 8]));

        // W=64: first 256 bits
        dack64 = 1'b1;
        for (int m = 0; m < 4; m++) begin
            check("w64_word", dout64, gold_a[m*64 +: 64]);
            cyc();
        end
        dack64 = 1'b0;

        // W=1: first 256 bits, serially
        dack1 = 1'b1;
        for (int j = 0; j < 256; j++) begin
            s1[j] = dout1[0];
            cyc();
        end
        dack1 = 1'b0;
        for (int m = 0; m < 4; m++) begin
            check("w1_stream", s1[m*64 +: 64], gold_a[m*64 +: 64]);
        end

        // Re-key at INIT cycle 50
        Kin = KEY_A; IVin = 80'h0; Krdy = 1'b1;
        cyc();
        Krdy = 1'b0;
        for (int c = 1; c < 50; c++) cyc();
        Kin = KEY_B; IVin = IV_B; Krdy = 1'b1;
        #1;
        check("rekey_bsy", 64'(bsy8), 64'd1);
        cyc();
        Krdy = 1'b0;
        #1;
        k8 = -1; bsy_drop = 0;
        for (int c = 1; c <= 200; c++) begin
            if (!bsy8 && k8 < 0) bsy_drop++;
            if (kvld8 && k8 < 0) k8 = c;
            cyc();
            #1;
        end
        check("rekey_kvld_lat", 64'(k8), 64'd144);
        check("rekey_bsy_hold", 64'(bsy_drop), 64'd0);
        check("rekey_w64_word0", dout64, gold_b[0 +: 64]);
        dack8 = 1'b1;
        for (int m = 0; m < 4; m++) begin
            check("rekey_w8_word", 64'(dout8), 64'(gold_b[m*8 +: 8]));
            cyc();
        end
        dack8 = 1'b0;

        // EN low for 10 cycles during INIT
        Krdy = 1'b1;
        cyc();
        Krdy = 1'b0;
        for (int c = 1; c < 20; c++) cyc();
        EN = 1'b0;
        #1;
        en_bad = 0;
        for (int c = 20; c < 30; c++) begin
            if (!bsy8 || kvld8) en_bad++;
            cyc();
            #1;
        end
        EN = 1'b1;
        #1;
        k8 = -1;
        for (int c = 30; c <= 200; c++) begin
            if (kvld8 && k8 < 0) k8 = c;
            cyc();
            #1;
        end
        check("en_low_kvld_lat", 64'(k8), 64'd154);
        check("en_low_hold", 64'(en_bad), 64'd0);
        dack8 = 1'b1;
        for (int m = 0; m < 2; m++) begin
            check("en_low_w8_word", 64'(dout8), 64'(gold_b[m*8 +: 8]));
            cyc();
        end
        dack8 = 1'b0;

        // Asynchronous reset mid-RUN, between clock edges
        #1;
        check("pre_rst_dvld", 64'(dvld8), 64'd1);
        #2 RST = 1'b1;
        #1;
        check("async_rst_dvld8", 64'(dvld8), 64'd0);
        check("async_rst_bsy8", 64'(bsy8), 64'd0);
        check("async_rst_dout8", 64'(dout8), 64'd0);
        check("async_rst_dvld64", 64'(dvld64), 64'd0);
        check("async_rst_dout64", dout64, 64'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        cyc();
        cyc();
        #1;
        check("post_rst_idle_dvld", 64'(dvld8), 64'd0);
        check("post_rst_idle_bsy", 64'(bsy8), 64'd0);
        check("post_rst_dout64", dout64, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trivium_stream.md
TRIVIUM_STREAM -- requirements
Module: trivium_stream

Interface
REQ-001 Parameter W, default 8: keystream bits produced per cycle; legal values 1, 2, 4, 8, 16, 32, 64; elaboration error otherwise.
REQ-002 CLK  in  1  system clock; all state changes on rising edge.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 EN  in  1  global enable; when low, all registers hold.
REQ-005 Kin  in  80  key, byte 0 in Kin[79:72].
REQ-006 IVin  in  80  IV, byte 0 in IVin[79:72].
REQ-007 Krdy  in  1  load strobe; samples Kin/IVin and starts initialisation.
REQ-008 Din  in  W  plaintext/ciphertext word; present only with TRIVIUM_XOR_EN.
REQ-009 Dack  in  1  consumer accepts current Dout.
REQ-010 Dout  out  W  keystream word, or Din XOR keystream with TRIVIUM_XOR_EN.
REQ-011 Dvld  out  1  Dout valid.
REQ-012 BSY  out  1  initialisation in progress.
REQ-013 Kvld  out  1  one-cycle pulse on the last initialisation cycle.

Function
REQ-014 FSM states IDLE, INIT, RUN; IDLE->INIT on Krdy; INIT->RUN when init counter reaches 1152/W-1; RUN->INIT on Krdy.
REQ-015 Load: key_r/iv_r are Kin/IVin with byte order reversed; state[79:0]=key_r, [92:80]=0, [172:93]=iv_r, [284:173]=0, [287:285]=3'b111; init counter cleared.
REQ-016 One step: t1=s[65]^s[92], t2=s[161]^s[176], t3=s[242]^s[287]; z=t1^t2^t3; t1^=(s[90]&s[91])^s[170]; t2^=(s[174]&s[175])^s[263]; t3^=(s[285]&s[286])^s[68]; s<={s[286:177],t2,s[175:93],t1,s[91:0],t3}.
REQ-017 Each advancing cycle applies W steps; first-generated bit lands in Dout[W-1], last in Dout[0].
REQ-018 INIT advances every EN cycle for exactly 1152/W cycles; no keystream exposed; BSY=1, Dvld=0.
REQ-019 In RUN, Dout is combinationally derived from current state (plus Din); Dvld=1; state advances only when EN&Dvld&Dack.
REQ-020 Dvld&!Dack: state and Dout (keystream part) held stable.
REQ-021 Krdy has priority over Dack and over INIT progress: Krdy in INIT restarts load and counter; Krdy in RUN discards current word.
REQ-022 First valid Dout appears the cycle after the Kvld pulse; latency Krdy -> Dvld = 1152/W+1 cycles with EN held high.
REQ-023 EN low: FSM, counter, state frozen; Dvld/BSY keep value; Kvld held low.

Reset
REQ-024 RST asynchronously forces IDLE, state=0, counter=0, Dvld=0, BSY=0, Kvld=0, Dout=0.
REQ-025 RST mid-INIT or mid-RUN discards key material; new Krdy required.

Configuration
REQ-026 TRIVIUM_XOR_EN defined: Din port exists, Dout=Din^keystream, Din sampled combinationally with Dack.
REQ-027 TRIVIUM_XOR_EN undefined: no Din port, Dout=raw keystream; all other behaviour identical.

Structure
REQ-028 Package trivium_pkg holds: STATE_W=288, INIT_STEPS=1152, key/IV width 80, tap index constants, FSM state enum.
REQ-029 Sub-module trivium_round: combinational single step (state in -> state out, z); top chains W instances.

Verification
REQ-030 Key=0, IV=0, W=1 and W=64: Krdy pulse -> Kvld after 1152 and 18 cycles; first 256 keystream bits match golden model; W=1 and W=64 streams bit-identical.
REQ-031 W=8, Dack low 5 cycles in RUN -> Dout/state unchanged; Dack high -> next word equals golden bits 8..15.
REQ-032 Krdy again at INIT cycle 50 with new key -> BSY stays high, Kvld 1152/W cycles after second Krdy, stream matches new key.
REQ-033 RST asserted mid-RUN, asynchronously between edges -> Dvld, BSY, Dout drop to 0 immediately; IDLE after release.
REQ-034 EN low 10 cycles during INIT -> Kvld delayed exactly 10 cycles; stream unchanged.
REQ-035 TRIVIUM_XOR_EN, Din=8'hFF -> Dout = bitwise NOT of golden keystream byte.
